// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS core hazard logic: register-zero constant,
// multiply/divide FSM states and the dependency match helper.
package cpu_pkg;

   localparam logic [4:0]  REG_ZERO   = 5'd0;
   localparam int unsigned MD_LAT_DEF = 4;

   typedef enum logic {
      IDLE,
      BUSY
   } md_state_t;

   // Register $0 is hard-wired, so it can never carry a true dependency.
   function automatic logic reg_match(input logic [4:0] r,
                                      input logic [4:0] rs,
                                      input logic [4:0] rt,
                                      input logic       uses_rt);
      return (r != REG_ZERO) && ((r == rs) || (uses_rt && (r == rt)));
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-stage hazard signal bundle: pipeline status in, front-end controls out.
interface hazard_ctrl_if #(
   parameter int unsigned CNT_W = 32
);
   logic [4:0]       ifid_rs;
   logic [4:0]       ifid_rt;
   logic             ifid_uses_rt;
   logic             id_branch;
   logic             id_branch_cond;
   logic             id_md_start;
   logic             id_md_use;
   logic             idex_memread;
   logic             idex_regwrite;
   logic [4:0]       idex_rd;
   logic             exmem_memread;
   logic [4:0]       exmem_rd;
   logic             PCWrite;
   logic             IFIDWrite;
   logic             branchtakken;
   logic             ctrl_bubble;
   logic             md_busy;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output ifid_rs, ifid_rt, ifid_uses_rt, id_branch, id_branch_cond,
             id_md_start, id_md_use, idex_memread, idex_regwrite, idex_rd,
             exmem_memread, exmem_rd,
      input  PCWrite, IFIDWrite, branchtakken, ctrl_bubble, md_busy, stall_count
   );

   modport slave (
      input  ifid_rs, ifid_rt, ifid_uses_rt, id_branch, id_branch_cond,
             id_md_start, id_md_use, idex_memread, idex_regwrite, idex_rd,
             exmem_memread, exmem_rd,
      output PCWrite, IFIDWrite, branchtakken, ctrl_bubble, md_busy, stall_count
   );

endinterface

// File: rtl/md_busy_timer.sv
// Multiply/divide occupancy timer: IDLE/BUSY FSM with a 4-bit down-counter,
// busy for exactly MD_LAT cycles after an accepted start.
module md_busy_timer
   import cpu_pkg::*;
#(
   parameter int unsigned MD_LAT = MD_LAT_DEF
) (
   input  logic clock,
   input  logic reset,
   input  logic start,
   output logic busy
);

   md_state_t  state, state_n;
   logic [3:0] md_cnt, md_cnt_n;

   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= IDLE;
         md_cnt <= '0;
      end else begin
         state  <= state_n;
         md_cnt <= md_cnt_n;
      end
   end

   always_comb begin
      state_n  = state;
      md_cnt_n = md_cnt;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_n  = BUSY;
               md_cnt_n = 4'(MD_LAT - 1);
            end
         end
         BUSY: begin
            if (md_cnt == '0) begin
               state_n = IDLE;
            end else begin
               md_cnt_n = md_cnt - 4'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign busy = (state == BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and front-end sequencing controller beside the ID stage:
// stall/flush/bubble generation, branch squash and stall cycle counting.
module hazard_ctrl
   import cpu_pkg::*;
#(
   parameter int unsigned MD_LAT = MD_LAT_DEF,
   parameter int unsigned CNT_W  = 32
) (
   input  logic          clock,
   input  logic          reset,
   hazard_ctrl_if.slave  hz
);

   logic             md_busy;
   logic             idex_hit;
   logic             exmem_hit;
   logic             stall;
   logic [CNT_W-1:0] stall_cnt;

   assign idex_hit  = reg_match(hz.idex_rd,  hz.ifid_rs, hz.ifid_rt, hz.ifid_uses_rt);
   assign exmem_hit = reg_match(hz.exmem_rd, hz.ifid_rs, hz.ifid_rt, hz.ifid_uses_rt);

   // A branch right after its load trips load-use then branch-on-load: 2 cycles.
   assign stall = (hz.idex_memread && idex_hit)
                | (hz.id_branch && hz.idex_regwrite && !hz.idex_memread && idex_hit)
                | (hz.id_branch && hz.exmem_memread && exmem_hit)
                | (md_busy && hz.id_md_use);

   md_busy_timer #(
      .MD_LAT (MD_LAT)
   ) u_md_timer (
      .clock (clock),
      .reset (reset),
      .start (hz.id_md_start && !stall),
      .busy  (md_busy)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (stall) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

   always_comb begin
      hz.PCWrite      = 1'b1;
      hz.IFIDWrite    = 1'b0;
      hz.branchtakken = 1'b0;
      hz.ctrl_bubble  = 1'b0;
      if (reset || stall) begin
         hz.PCWrite     = 1'b0;
         hz.IFIDWrite   = 1'b1;
         hz.ctrl_bubble = 1'b1;
      end else if (hz.id_branch && hz.id_branch_cond) begin
         hz.branchtakken = 1'b1;
      end
   end

   assign hz.md_busy     = md_busy;
   assign hz.stall_count = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with hand-computed expectations.
module tb_hazard_ctrl;

   logic clock = 1'b0;
   logic reset;
   int unsigned n_chk = 0;
   int unsigned n_bad = 0;
   int unsigned exp_cnt = 0;

   hazard_ctrl_if #(.CNT_W(32)) hif ();

   hazard_ctrl #(
      .MD_LAT (4),
      .CNT_W  (32)
   ) dut (
      .clock (clock),
      .reset (reset),
      .hz    (hif.slave)
   );

   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
      end
   endtask

   task automatic chk_out(input string tag, input logic pc, input logic ifw,
                          input logic bt, input logic bub);
      check_eq({tag, ".pc"},  32'(hif.PCWrite),      32'(pc));
      check_eq({tag, ".ifw"}, 32'(hif.IFIDWrite),    32'(ifw));
      check_eq({tag, ".bt"},  32'(hif.branchtakken), 32'(bt));
      check_eq({tag, ".bub"}, 32'(hif.ctrl_bubble),  32'(bub));
   endtask

   task automatic tick(input string tag, input logic st);
      @(posedge clock);
      #1;
      if (st) exp_cnt++;
      check_eq({tag, ".cnt"}, hif.stall_count, exp_cnt);
   endtask

   task automatic clr();
      hif.ifid_rs        = '0;
      hif.ifid_rt        = '0;
      hif.ifid_uses_rt   = 1'b0;
      hif.id_branch      = 1'b0;
      hif.id_branch_cond = 1'b0;
      hif.id_md_start    = 1'b0;
      hif.id_md_use      = 1'b0;
      hif.idex_memread   = 1'b0;
      hif.idex_regwrite  = 1'b0;
      hif.idex_rd        = '0;
      hif.exmem_memread  = 1'b0;
      hif.exmem_rd       = '0;
   endtask

   initial begin
      clr();
      reset = 1'b1;
      @(posedge clock);
      @(posedge clock);
      #1;
      chk_out("rst", 1'b0, 1'b1, 1'b0, 1'b1);
      check_eq("rst.busy", 32'(hif.md_busy), 32'd0);
      check_eq("rst.cnt", hif.stall_count, 32'd0);
      reset = 1'b0;
      #1 chk_out("post_rst", 1'b1, 1'b0, 1'b0, 1'b0);

      // register $0 never hazards
      hif.idex_memread = 1'b1; hif.ifid_uses_rt = 1'b1;
      #1 chk_out("r0", 1'b1, 1'b0, 1'b0, 1'b0);
      tick("r0", 1'b0);

      // rt matches but is not a source
      clr(); hif.idex_memread = 1'b1; hif.idex_rd = 5'd7; hif.ifid_rt = 5'd7; hif.ifid_rs = 5'd3;
      #1 chk_out("rt_unused", 1'b1, 1'b0, 1'b0, 1'b0);
      tick("rt_unused", 1'b0);
      hif.ifid_uses_rt = 1'b1;
      #1 chk_out("lu_rt", 1'b0, 1'b1, 1'b0, 1'b1);
      tick("lu_rt", 1'b1);

      // load-use on rs
      clr(); hif.idex_memread = 1'b1; hif.idex_rd = 5'd8; hif.ifid_rs = 5'd8;
      #1 chk_out("lu", 1'b0, 1'b1, 1'b0, 1'b1);
      tick("lu", 1'b1);
      clr();
      #1 chk_out("lu_after", 1'b1, 1'b0, 1'b0, 1'b0);
      tick("lu_after", 1'b0);

      // taken beq directly after load to $9: 2 stalls then one squash cycle
      hif.idex_memread = 1'b1; hif.idex_rd = 5'd9; hif.ifid_rs = 5'd9;
      hif.id_branch = 1'b1; hif.id_branch_cond = 1'b1;
      #1 chk_out("bl1", 1'b0, 1'b1, 1'b0, 1'b1);
      tick("bl1", 1'b1);
      hif.idex_memread = 1'b0; hif.idex_rd = '0; hif.exmem_memread = 1'b1; hif.exmem_rd = 5'd9;
      #1 chk_out("bl2", 1'b0, 1'b1, 1'b0, 1'b1);
      tick("bl2", 1'b1);
      hif.exmem_memread = 1'b0; hif.exmem_rd = '0;
      #1 chk_out("bl_take", 1'b1, 1'b0, 1'b1, 1'b0);
      tick("bl_take", 1'b0);
      clr();
      #1 chk_out("bl_after", 1'b1, 1'b0, 1'b0, 1'b0);
      tick("bl_after", 1'b0);

      // branch on ALU result in EX: 1 stall, not-taken afterwards
      hif.idex_regwrite = 1'b1; hif.idex_rd = 5'd5; hif.ifid_rt = 5'd5; hif.ifid_uses_rt = 1'b1;
      hif.ifid_rs = 5'd2; hif.id_branch = 1'b1;
      #1 chk_out("balu", 1'b0, 1'b1, 1'b0, 1'b1);
      tick("balu", 1'b1);
      hif.idex_regwrite = 1'b0; hif.idex_rd = '0;
      #1 chk_out("balu_nt", 1'b1, 1'b0, 1'b0, 1'b0);
      tick("balu_nt", 1'b0);

      // ALU dependency without a branch is forwarded, no stall
      clr(); hif.idex_regwrite = 1'b1; hif.idex_rd = 5'd5; hif.ifid_rs = 5'd5;
      #1 chk_out("alu_fwd", 1'b1, 1'b0, 1'b0, 1'b0);
      tick("alu_fwd", 1'b0);

      // taken branch, no hazard
      clr(); hif.id_branch = 1'b1; hif.id_branch_cond = 1'b1;
      #1 chk_out("bt", 1'b1, 1'b0, 1'b1, 1'b0);
      tick("bt", 1'b0);
      clr();
      #1 chk_out("bt_after", 1'b1, 1'b0, 1'b0, 1'b0);

      // md start blocked by a load-use stall
      hif.idex_memread = 1'b1; hif.idex_rd = 5'd4; hif.ifid_rs = 5'd4;
      hif.id_md_start = 1'b1; hif.id_md_use = 1'b1;
      #1 chk_out("md_blk", 1'b0, 1'b1, 1'b0, 1'b1);
      tick("md_blk", 1'b1);
      check_eq("md_blk.busy", 32'(hif.md_busy), 32'd0);

      // start accepted, then mflo stalls MD_LAT cycles
      hif.idex_memread = 1'b0; hif.idex_rd = '0;
      #1 chk_out("md_go", 1'b1, 1'b0, 1'b0, 1'b0);
      tick("md_go", 1'b0);
      hif.id_md_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         hif.idex_memread = (i == 1);
         hif.idex_rd      = (i == 1) ? 5'd4 : 5'd0;
         #1;
         check_eq($sformatf("mflo%0d.busy", i), 32'(hif.md_busy), 32'd1);
         chk_out($sformatf("mflo%0d", i), 1'b0, 1'b1, 1'b0, 1'b1);
         tick($sformatf("mflo%0d", i), 1'b1);
      end
      hif.idex_memread = 1'b0; hif.idex_rd = '0;
      #1 check_eq("mflo_done.busy", 32'(hif.md_busy), 32'd0);
      chk_out("mflo_done", 1'b1, 1'b0, 1'b0, 1'b0);
      tick("mflo_done", 1'b0);

      // independent add after a start, then reset mid-busy
      clr(); hif.id_md_start = 1'b1; hif.id_md_use = 1'b1;
      #1 chk_out("md2", 1'b1, 1'b0, 1'b0, 1'b0);
      tick("md2", 1'b0);
      clr(); hif.ifid_rs = 5'd4;
      #1 check_eq("add.busy", 32'(hif.md_busy), 32'd1);
      chk_out("add", 1'b1, 1'b0, 1'b0, 1'b0);
      tick("add", 1'b0);
      reset = 1'b1;
      #1 chk_out("rst_mid", 1'b0, 1'b1, 1'b0, 1'b1);
      @(posedge clock);
      #1 reset = 1'b0;
      exp_cnt = 0;
      check_eq("rst_mid.busy", 32'(hif.md_busy), 32'd0);
      check_eq("rst_mid.cnt", hif.stall_count, exp_cnt);
      #1 chk_out("rst_mid_after", 1'b1, 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
